// File: rtl/bus_poller.sv
// Round-robin reader for a shared tri-state bus: enables one source at a time,
// waits SETTLE cycles, captures the bus and offers it downstream via valid/ready.
module bus_poller #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SETTLE  = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [WIDTH-1:0]           bus_in,
    output logic [NUM_SRC-1:0]         en_out,
    output logic [WIDTH-1:0]           dato,
    output logic [$clog2(NUM_SRC)-1:0] fuente,
    output logic                       valido,
    input  logic                       listo,
    output logic                       ocupado
);
    localparam int unsigned IW = $clog2(NUM_SRC);

    typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, HOLD} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_nxt;
    logic [3:0]    cnt;

    assign idx_nxt = idx + IW'(1);

    // en_out and ocupado are loaded on the transitions that lead into the
    // states where they apply, so they stay pure flop outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            en_out  <= '0;
            dato    <= '0;
            fuente  <= '0;
            valido  <= 1'b0;
            ocupado <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx     <= '0;
                        cnt     <= '0;
                        en_out  <= NUM_SRC'(1);
                        ocupado <= 1'b1;
                        state   <= DRIVE;
                    end
                end
                DRIVE: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'(SETTLE - 1)) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    dato   <= bus_in;
                    fuente <= idx;
                    valido <= 1'b1;
                    en_out <= '0;
                    state  <= HOLD;
                end
                HOLD: begin
                    if (listo) begin
                        valido <= 1'b0;
                        cnt    <= '0;
                        if (idx == IW'(NUM_SRC - 1)) begin
                            idx <= '0;
                            if (start) begin
                                en_out <= NUM_SRC'(1);
                                state  <= DRIVE;
                            end else begin
                                ocupado <= 1'b0;
                                state   <= IDLE;
                            end
                        end else begin
                            idx    <= idx_nxt;
                            en_out <= NUM_SRC'(1) << idx_nxt;
                            state  <= DRIVE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/bus_poller.md
Name: bus_poller

Overview:
- Reader/master for a shared tri-state bus fed by several 4-bit enable-controlled buffers.
- Generates the one-hot enables that turn each buffer on in round-robin order.
- Waits a settle interval, captures the bus value, and presents it downstream with a valid/ready handshake.
- Only one source drives the bus at a time. There is always at least one cycle with no enable asserted between two sources (break-before-make).

Parameters:
- WIDTH, 4, bus data width in bits.
- NUM_SRC, 4, number of tri-state sources on the bus (2..16).
- SETTLE, 1, cycles the enable is held before capture (1..15).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous active-low reset (0 = reset).
- start  input  1  level request to begin or continue scanning; sampled in IDLE and at end of each scan.
- bus_in  input  WIDTH  shared tri-state bus value.
- en_out  output  NUM_SRC  one-hot enables to source buffers; all-zero when no source is selected.
- dato  output  WIDTH  captured bus value.
- fuente  output  $clog2(NUM_SRC)  index of the source that produced dato.
- valido  output  1  dato/fuente valid.
- listo  input  1  downstream ready; transfer occurs when valido && listo at a rising edge.
- ocupado  output  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous, reset=0) forces:
  - state=IDLE, en_out=0, dato=0, fuente=0, valido=0, ocupado=0.
  - Internal index idx=0 and settle counter cnt=0.
  - Applies immediately, including mid-scan.
  - On release, the first activity is at the first edge with start=1.
- States: IDLE, DRIVE, CAPTURE, HOLD.
- IDLE:
  - en_out=0.
  - On an edge with start=1: idx<=0, cnt<=0, go to DRIVE. Otherwise stay in IDLE.
- DRIVE:
  - en_out=1<<idx.
  - cnt increments each edge.
  - When cnt==SETTLE-1, go to CAPTURE.
- CAPTURE:
  - en_out is still 1<<idx.
  - At the edge: dato<=bus_in, fuente<=idx, valido<=1, go to HOLD.
- HOLD:
  - en_out=0, valido=1. dato and fuente are stable and do not change while valido=1 and listo=0.
  - On an edge with listo=1: valido<=0, cnt<=0.
    - If idx<NUM_SRC-1: idx<=idx+1, go to DRIVE.
    - If idx==NUM_SRC-1: idx<=0 (wrap). Go to DRIVE if start=1, else IDLE.
- start changes during DRIVE, CAPTURE or HOLD have no effect until the scan end. A scan is never aborted except by reset.
- Latency: the start edge to valido rising is SETTLE+2 edges.
  - With SETTLE=1, listo held at 1 and continuous start, one sample is produced every 3 cycles.
- en_out:
  - Never has more than one bit set.
  - Always all-zero for at least one cycle between different sources (the HOLD cycle).
- listo may be high before valido rises. The transfer then completes on the first HOLD edge.
- bus_in is not sampled outside CAPTURE. A floating bus captured by an external misconfiguration is passed through unchanged; no X/Z detection.
- Registered outputs: en_out, dato, fuente, valido and ocupado are driven by flops or decoded from state only; no combinational path from listo or start to outputs.

Test Plan:
- Reset and idle:
  - Assert reset=0 mid-DRIVE with en_out=0010 -> en_out, valido, ocupado go 0 immediately, dato=0.
  - Release with start=0 for 5 cycles -> remains IDLE, en_out=0000.
- Single scan:
  - Bench models four buffers driving constants 0101, 0100, 0001, 1001 onto bus_in; start pulsed for 1 cycle; listo=1 always.
  - Outputs are (fuente,dato) = (0,0101), (1,0100), (2,0001), (3,1001), each valido exactly 1 cycle, 3 cycles apart; then IDLE, ocupado=0.
- Backpressure:
  - listo=0 for 4 cycles while valido=1 on source 1 -> dato=0100, fuente=1 held and en_out=0000 throughout.
  - Release listo -> source 2 is enabled on the next cycle.
- Continuous scan:
  - start held at 1 -> after fuente=3, idx wraps and fuente=0 data follows with no IDLE cycle.
  - Drop start during the source 1 DRIVE -> scan finishes source 3, then IDLE.
- Bus exclusivity:
  - Over 200 cycles of random listo/start -> $countones(en_out)<=1 every cycle.
  - en_out is 0 for at least 1 cycle between every change of the selected bit.
- Settle parameter:
  - SETTLE=3 -> en_out held 4 cycles (3 DRIVE + CAPTURE) per source; start to first valido = 5 edges.
